branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch direction predictor that produces `prediction` and `misprediction` for the pipeline stall/flush controller.
- Looks up a table of 2-bit saturating counters (BHT) with the ID-stage PC of a conditional branch.
- Carries the predicted direction through the ID/EXE boundary, compares it with the resolved outcome in EXE, and trains the counter.
- Also keeps saturating branch and misprediction statistics counters.

Parameters:
- IDX_W, 6, log2 of BHT entries (64 counters); index = pc[IDX_W+1:2].
- INIT_CTR, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_pc  input  32  PC of instruction in ID.
- id_branch  input  2  ID decode branch class: 00 none, 01 conditional branch, 1x jump.
- id_ex_en  input  1  ID/EXE register advances this cycle.
- id_ex_flush  input  1  ID/EXE register loads a bubble this cycle.
- ex_pc  input  32  PC of instruction in EXE.
- ex_branch  input  2  EXE-stage branch class, same encoding as id_branch.
- ex_taken  input  1  resolved direction of the EXE conditional branch.
- prediction  output  1  predicted taken for the ID conditional branch (combinational).
- misprediction  output  1  EXE conditional branch resolved opposite to its prediction (combinational).
- ex_pred  output  1  registered prediction bit of the EXE-stage instruction.
- br_cnt  output  32  conditional branches resolved in EXE.
- mp_cnt  output  32  mispredictions detected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all BHT counters = INIT_CTR;
  - ex_pred = 0; br_cnt = 0; mp_cnt = 0.
  - prediction and misprediction are then determined by their inputs: with INIT_CTR = 01, prediction = 0.
- Lookup, ID stage, zero latency:
  - idx_id = id_pc[IDX_W+1:2].
  - prediction = (id_branch == 2'b01) & BHT[idx_id][1].
  - Jumps (id_branch[1] = 1) and non-branches give prediction = 0.
- ID/EXE prediction register, rising edge of clk:
  - if id_ex_flush: ex_pred <= 0;
  - else if id_ex_en: ex_pred <= prediction;
  - else ex_pred holds.
  - Flush has priority over enable.
- Resolution, EXE stage, combinational:
  - misprediction = (ex_branch == 2'b01) & (ex_taken != ex_pred).
  - Jumps and bubbles never mispredict.
- Training, rising edge, when ex_branch == 2'b01:
  - idx_ex = ex_pc[IDX_W+1:2].
  - ex_taken = 1: BHT[idx_ex] increments, saturating at 2'b11.
  - ex_taken = 0: BHT[idx_ex] decrements, saturating at 2'b00.
  - Training occurs regardless of id_ex_en and id_ex_flush.
  - No other entry changes.
- Same-cycle read/write of one index: the ID lookup sees the pre-update value. No bypass.
- Counter state meanings: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Statistics, rising edge:
  - br_cnt += 1 when ex_branch == 2'b01.
  - mp_cnt += 1 when misprediction.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- Aliasing: PCs sharing idx bits share one counter. This is accepted and not detected.
- Reset asserted mid-operation: all state returns to reset values immediately. The first edge after deassertion behaves as post-reset.
- X-safety: with id_branch = 00 and ex_branch = 00 (unused/idle inputs), no state changes except ex_pred loading 0 on enable.

Test Plan:
- Reset then id_pc = 0x40, id_branch = 01 -> prediction = 0. Sample after rst_n high: ex_pred = 0, br_cnt = 0, mp_cnt = 0.
- Branch at 0x40 resolves taken twice (ex_branch = 01, ex_taken = 1, ex_pred = 0):
  - 1st resolve -> misprediction = 1, counter 01->10;
  - 2nd resolve -> counter 10->11;
  - then ID lookup of 0x40 -> prediction = 1;
  - br_cnt = 2, mp_cnt = 2.
- Saturation: counter at 11, resolve taken 3 more times -> stays 11. Then one not-taken -> 10, prediction still 1, misprediction = 1 on that resolve.
- Flush priority: id_branch = 01 with prediction = 1, id_ex_en = 1 and id_ex_flush = 1 same edge -> ex_pred = 0. With id_ex_en = 0 and flush = 0 -> ex_pred holds its prior value.
- Same index collision: ID lookup of 0x40 in the same cycle as EXE training of 0x140 (idx 16 = 0x40 idx when IDX_W = 6) -> prediction reflects the old counter; the next cycle reflects the updated counter.
- Jump and async reset: ex_branch = 10, ex_taken = 1 -> misprediction = 0, no BHT change, br_cnt unchanged. Then rst_n pulsed low mid-cycle -> counters read 01 and stats read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Pipeline-to-predictor signal bundle: ID lookup, ID/EXE register control, EXE resolution, results.
// Latency: none (wires only).
// Backpressure: none; the pipeline stalls through id_ex_en and flushes through id_ex_flush.
//
// Ports (master = pipeline side, slave = predictor side):
//   id_pc/id_branch        ID-stage PC and branch class (00 none, 01 conditional, 1x jump)
//   id_ex_en/id_ex_flush   ID/EXE register advance / bubble load
//   ex_pc/ex_branch/ex_taken  EXE-stage PC, branch class and resolved direction
//   prediction/misprediction/ex_pred  predictor results
//   br_cnt/mp_cnt          saturating statistics
interface branch_predictor_if;
  logic [31:0] id_pc;
  logic [1:0]  id_branch;
  logic        id_ex_en;
  logic        id_ex_flush;
  logic [31:0] ex_pc;
  logic [1:0]  ex_branch;
  logic        ex_taken;
  logic        prediction;
  logic        misprediction;
  logic        ex_pred;
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  modport master (
    output id_pc, id_branch, id_ex_en, id_ex_flush, ex_pc, ex_branch, ex_taken,
    input  prediction, misprediction, ex_pred, br_cnt, mp_cnt
  );

  modport slave (
    input  id_pc, id_branch, id_ex_en, id_ex_flush, ex_pc, ex_branch, ex_taken,
    output prediction, misprediction, ex_pred, br_cnt, mp_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counter table indexed by pc[IDX_W+1:2], plus stats.
// Latency: prediction/misprediction combinational; ex_pred, table training and stats update on the edge.
// Backpressure: ex_pred holds when id_ex_en is low; id_ex_flush loads a bubble (priority over enable).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (table -> INIT_CTR, ex_pred/stats -> 0)
//   bp     branch_predictor_if.slave bundle (see interface header for signal list)
module branch_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_predictor_if.slave   bp
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Counter table and registered state
  logic [1:0]  bht_q [ENTRIES];
  logic [1:0]  bht_d [ENTRIES];
  logic        ex_pred_q, ex_pred_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  // Decoded lookup / resolution terms
  logic [IDX_W-1:0] idx_id;
  logic [IDX_W-1:0] idx_ex;
  logic             id_cond;
  logic             ex_cond;
  logic             prediction;
  logic             misprediction;
  logic [1:0]       ex_ctr;

  assign idx_id  = bp.id_pc[IDX_W+1:2];
  assign idx_ex  = bp.ex_pc[IDX_W+1:2];
  assign id_cond = (bp.id_branch == 2'b01);
  assign ex_cond = (bp.ex_branch == 2'b01);
  assign ex_ctr  = bht_q[idx_ex];

  // The lookup reads the registered table, so a same-cycle training write to
  // the same index is only visible from the next cycle on (no bypass).
  assign prediction    = id_cond & bht_q[idx_id][1];
  assign misprediction = ex_cond & (bp.ex_taken != ex_pred_q);

  // Byte-offset bits and PC bits above the index do not take part in lookup;
  // aliasing between PCs sharing index bits is accepted.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.id_pc[31:IDX_W+2], bp.id_pc[1:0],
                            bp.ex_pc[31:IDX_W+2], bp.ex_pc[1:0]};

  always_comb begin
    bht_d     = bht_q;
    ex_pred_d = ex_pred_q;
    br_cnt_d  = br_cnt_q;
    mp_cnt_d  = mp_cnt_q;

    // Training happens on every resolved conditional branch, independent of
    // whether the ID/EXE register is stalled or flushed this cycle.
    if (ex_cond) begin
      if (bp.ex_taken) begin
        if (ex_ctr != 2'b11) begin
          bht_d[idx_ex] = ex_ctr + 2'd1;
        end
      end else begin
        if (ex_ctr != 2'b00) begin
          bht_d[idx_ex] = ex_ctr - 2'd1;
        end
      end
    end

    // Flush wins over enable so a squashed slot never carries a stale prediction.
    if (bp.id_ex_flush) begin
      ex_pred_d = 1'b0;
    end else if (bp.id_ex_en) begin
      ex_pred_d = prediction;
    end

    // Statistics stick at all-ones rather than wrapping.
    if (ex_cond && (br_cnt_q != CNT_MAX)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (misprediction && (mp_cnt_q != CNT_MAX)) begin
      mp_cnt_d = mp_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= INIT_CTR;
      end
      ex_pred_q <= 1'b0;
      br_cnt_q  <= 32'd0;
      mp_cnt_q  <= 32'd0;
    end else begin
      bht_q     <= bht_d;
      ex_pred_q <= ex_pred_d;
      br_cnt_q  <= br_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
    end
  end

  assign bp.prediction    = prediction;
  assign bp.misprediction = misprediction;
  assign bp.ex_pred       = ex_pred_q;
  assign bp.br_cnt        = br_cnt_q;
  assign bp.mp_cnt        = mp_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios followed by randomized traffic against a table model.
// Latency: checks combinational outputs 1 ns after inputs change, registered outputs on the following cycle.
// Backpressure: exercises id_ex_en stalls and id_ex_flush bubbles, including both asserted together.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.IDX_W(6), .INIT_CTR(2'b01)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  // Reference model: counters as plain integers 0..3, stats as wide integers.
  int     bht_m [64];
  bit     ex_pred_m;
  longint br_m;
  longint mp_m;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    ex_pred_m = 1'b0;
    br_m      = 0;
    mp_m      = 0;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit exp_pred();
    return (bp_if.id_branch == 2'b01) && (bht_m[idx_of(bp_if.id_pc)] >= 2);
  endfunction

  function automatic bit exp_misp();
    return (bp_if.ex_branch == 2'b01) && (bp_if.ex_taken != ex_pred_m);
  endfunction

  task automatic drive(input logic [31:0] ipc, input logic [1:0] ibr, input logic en,
                       input logic fl, input logic [31:0] xpc, input logic [1:0] xbr,
                       input logic xt);
    bp_if.id_pc       = ipc;
    bp_if.id_branch   = ibr;
    bp_if.id_ex_en    = en;
    bp_if.id_ex_flush = fl;
    bp_if.ex_pc       = xpc;
    bp_if.ex_branch   = xbr;
    bp_if.ex_taken    = xt;
  endtask

  task automatic check_outputs();
    chk("prediction",    {31'd0, bp_if.prediction},    {31'd0, exp_pred()});
    chk("misprediction", {31'd0, bp_if.misprediction}, {31'd0, exp_misp()});
    chk("ex_pred",       {31'd0, bp_if.ex_pred},       {31'd0, ex_pred_m});
    chk("br_cnt",        bp_if.br_cnt, br_m[31:0]);
    chk("mp_cnt",        bp_if.mp_cnt, mp_m[31:0]);
  endtask

  // One clock cycle: check outputs, then advance the model across the edge.
  task automatic cycle();
    bit p, m;
    int i;
    #1;
    check_outputs();
    p = exp_pred();
    m = exp_misp();
    @(posedge clk);
    if (bp_if.id_ex_flush)   ex_pred_m = 1'b0;
    else if (bp_if.id_ex_en) ex_pred_m = p;
    if (bp_if.ex_branch == 2'b01) begin
      i = idx_of(bp_if.ex_pc);
      bht_m[i] = bp_if.ex_taken ? ((bht_m[i] < 3) ? bht_m[i] + 1 : 3)
                                : ((bht_m[i] > 0) ? bht_m[i] - 1 : 0);
      if (br_m < 64'hFFFF_FFFF) br_m++;
    end
    if (m && mp_m < 64'hFFFF_FFFF) mp_m++;
    @(negedge clk);
  endtask

  // Reset pulse starting mid-cycle; outputs must clear without any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] br_before;

    // Reset state
    rst_n = 1'b0;
    model_reset();
    drive(32'h40, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    #1;
    chk("rst_pred", {31'd0, bp_if.prediction}, 32'd0);
    chk("rst_ex_pred", {31'd0, bp_if.ex_pred}, 32'd0);
    chk("rst_br_cnt", bp_if.br_cnt, 32'd0);
    chk("rst_mp_cnt", bp_if.mp_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Two taken resolutions at 0x40 while ex_pred is 0: 01 -> 10 -> 11
    drive(32'h0, 2'b00, 1'b1, 1'b0, 32'h40, 2'b01, 1'b1);
    #1 chk("train1_misp", {31'd0, bp_if.misprediction}, 32'd1);
    cycle();
    cycle();
    drive(32'h40, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    #1;
    chk("trained_pred", {31'd0, bp_if.prediction}, 32'd1);
    chk("trained_br", bp_if.br_cnt, 32'd2);
    chk("trained_mp", bp_if.mp_cnt, 32'd2);
    cycle();

    // Saturation at 11 while ex_pred picks up prediction 1, then one not-taken
    drive(32'h40, 2'b01, 1'b1, 1'b0, 32'h40, 2'b01, 1'b1);
    repeat (3) cycle();
    drive(32'h40, 2'b01, 1'b1, 1'b0, 32'h40, 2'b01, 1'b0);
    #1 chk("nt_misp", {31'd0, bp_if.misprediction}, 32'd1);
    cycle();
    drive(32'h40, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    #1 chk("sat_pred_still_1", {31'd0, bp_if.prediction}, 32'd1);
    cycle();

    // Flush beats enable; no enable holds
    drive(32'h40, 2'b01, 1'b1, 1'b1, 32'h0, 2'b00, 1'b0);
    cycle();
    #1 chk("flush_prio", {31'd0, bp_if.ex_pred}, 32'd0);
    drive(32'h40, 2'b01, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    cycle();
    drive(32'h40, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    cycle();
    #1 chk("hold", {31'd0, bp_if.ex_pred}, 32'd1);

    // Same-index collision: 0x140 aliases 0x40 (counter at 10)
    drive(32'h40, 2'b01, 1'b0, 1'b0, 32'h140, 2'b01, 1'b0);
    #1 chk("collide_old", {31'd0, bp_if.prediction}, 32'd1);
    cycle();
    drive(32'h40, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    #1 chk("collide_new", {31'd0, bp_if.prediction}, 32'd0);
    cycle();

    // Jump in EXE: no mispredict, no training, no count
    br_before = bp_if.br_cnt;
    drive(32'h40, 2'b01, 1'b0, 1'b0, 32'h40, 2'b10, 1'b1);
    #1 chk("jump_misp", {31'd0, bp_if.misprediction}, 32'd0);
    cycle();
    #1 chk("jump_br_cnt", bp_if.br_cnt, br_before);
    chk("jump_no_train", {31'd0, bp_if.prediction}, 32'd0);

    // Train 0x80 to strongly taken, then async reset mid-cycle
    drive(32'h80, 2'b01, 1'b1, 1'b0, 32'h80, 2'b01, 1'b1);
    repeat (2) cycle();
    #1 chk("pre_rst_pred", {31'd0, bp_if.prediction}, 32'd1);
    async_reset();
    #1 chk("post_rst_pred", {31'd0, bp_if.prediction}, 32'd0);
    cycle();

    // Randomized traffic over a small PC pool so aliasing and saturation occur
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ipc, xpc;
      ipc = {22'd0, 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      xpc = {22'd0, 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      drive(ipc, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 5) == 0),
            xpc, ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 149) == 0) async_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
